// File: rtl/issue_queue.sv
// issue_queue: in-order instruction issue queue between fetch and the
// ROB / reservation station / load-store buffer.
//
// Ports:
//   clk_in, rst_in           clock, async active-low reset
//   rdy_in                   global enable; low freezes all state
//   clear_in                 synchronous flush (branch mispredict)
//   inst_valid_in, inst_in,  push request with instruction word and PC
//   inst_addr_in
//   full_out, count_out      occupancy status, derived from the pointers
//   rob_full_in,             downstream back-pressure and ROB tag
//   rob_tail_id_in,
//   rs_full_in, lsb_full_in
//   disp_*_out               registered dispatch pulse and payload
module issue_queue #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned ROB_W = 5,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear_in,
  input  logic             inst_valid_in,
  input  logic [31:0]      inst_in,
  input  logic [31:0]      inst_addr_in,
  output logic             full_out,
  output logic [PTR_W:0]   count_out,
  input  logic             rob_full_in,
  input  logic [ROB_W-1:0] rob_tail_id_in,
  input  logic             rs_full_in,
  input  logic             lsb_full_in,
  output logic             disp_valid_out,
  output logic [31:0]      disp_inst_out,
  output logic [31:0]      disp_addr_out,
  output logic [ROB_W-1:0] disp_rob_id_out,
  output logic             disp_to_rs_out,
  output logic             disp_to_lsb_out
);

  localparam int unsigned IW    = 32;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;

  // Entry storage; contents are never reset, validity comes from the pointers.
  logic [IW-1:0] inst_mem [DEPTH];
  logic [IW-1:0] addr_mem [DEPTH];

  logic [CNT_W-1:0] head_q, head_d;
  logic [CNT_W-1:0] tail_q, tail_d;

  logic             disp_valid_q, disp_valid_d;
  logic [IW-1:0]    disp_inst_q, disp_inst_d;
  logic [IW-1:0]    disp_addr_q, disp_addr_d;
  logic [ROB_W-1:0] disp_rob_q, disp_rob_d;
  logic             disp_rs_q, disp_rs_d;
  logic             disp_lsb_q, disp_lsb_d;

  logic             empty_c;
  logic             full_c;
  logic             push_c;
  logic             pop_c;
  logic             head_is_lsb_c;
  logic [IW-1:0]    head_inst_c;
  logic [IW-1:0]    head_addr_c;

  // Occupancy status from the registered pointers.
  always_comb begin
    empty_c = (head_q == tail_q);
    full_c  = (head_q[PTR_W] != tail_q[PTR_W]) &&
              (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]);
  end

  assign full_out  = full_c;
  assign count_out = tail_q - head_q;

  // Head entry and its target class (loads/stores go to the LSB).
  always_comb begin
    head_inst_c   = inst_mem[head_q[PTR_W-1:0]];
    head_addr_c   = addr_mem[head_q[PTR_W-1:0]];
    head_is_lsb_c = (head_inst_c[6:0] == OP_LOAD) ||
                    (head_inst_c[6:0] == OP_STORE);
  end

  // Push and pop qualification; a stalled head blocks everything behind it.
  always_comb begin
    push_c = rdy_in && !clear_in && inst_valid_in && !full_c;
    pop_c  = rdy_in && !clear_in && !empty_c && !rob_full_in &&
             (head_is_lsb_c ? !lsb_full_in : !rs_full_in);
  end

  // Next-state: hold by default, clear overrides push and pop.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    disp_valid_d = disp_valid_q;
    disp_inst_d  = disp_inst_q;
    disp_addr_d  = disp_addr_q;
    disp_rob_d   = disp_rob_q;
    disp_rs_d    = disp_rs_q;
    disp_lsb_d   = disp_lsb_q;
    if (rdy_in) begin
      disp_valid_d = 1'b0;
      if (clear_in) begin
        head_d = '0;
        tail_d = '0;
      end else begin
        if (push_c) begin
          tail_d = tail_q + CNT_W'(1);
        end
        if (pop_c) begin
          head_d       = head_q + CNT_W'(1);
          disp_valid_d = 1'b1;
          disp_inst_d  = head_inst_c;
          disp_addr_d  = head_addr_c;
          disp_rob_d   = rob_tail_id_in;
          disp_rs_d    = !head_is_lsb_c;
          disp_lsb_d   = head_is_lsb_c;
        end
      end
    end
  end

  // Pointer and dispatch registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q       <= '0;
      tail_q       <= '0;
      disp_valid_q <= 1'b0;
      disp_inst_q  <= '0;
      disp_addr_q  <= '0;
      disp_rob_q   <= '0;
      disp_rs_q    <= 1'b0;
      disp_lsb_q   <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      disp_valid_q <= disp_valid_d;
      disp_inst_q  <= disp_inst_d;
      disp_addr_q  <= disp_addr_d;
      disp_rob_q   <= disp_rob_d;
      disp_rs_q    <= disp_rs_d;
      disp_lsb_q   <= disp_lsb_d;
    end
  end

  // Storage write at tail.
  always_ff @(posedge clk_in) begin
    if (push_c) begin
      inst_mem[tail_q[PTR_W-1:0]] <= inst_in;
      addr_mem[tail_q[PTR_W-1:0]] <= inst_addr_in;
    end
  end

  assign disp_valid_out  = disp_valid_q;
  assign disp_inst_out   = disp_inst_q;
  assign disp_addr_out   = disp_addr_q;
  assign disp_rob_id_out = disp_rob_q;
  assign disp_to_rs_out  = disp_rs_q;
  assign disp_to_lsb_out = disp_lsb_q;

endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: a table of single-cycle vectors followed by
// hand-written sequences for fill/drain, flush, wrap and mid-stream reset.
module tb_issue_queue;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned ROB_W = 5;
  localparam int unsigned CW    = 5;

  localparam logic [31:0] ADD = 32'h00208033;
  localparam logic [31:0] LW  = 32'h0000a103;
  localparam logic [31:0] SW  = 32'h0020a023;

  logic             clk_in;
  logic             rst_in;
  logic             rdy_in;
  logic             clear_in;
  logic             inst_valid_in;
  logic [31:0]      inst_in;
  logic [31:0]      inst_addr_in;
  logic             full_out;
  logic [CW-1:0]    count_out;
  logic             rob_full_in;
  logic [ROB_W-1:0] rob_tail_id_in;
  logic             rs_full_in;
  logic             lsb_full_in;
  logic             disp_valid_out;
  logic [31:0]      disp_inst_out;
  logic [31:0]      disp_addr_out;
  logic [ROB_W-1:0] disp_rob_id_out;
  logic             disp_to_rs_out;
  logic             disp_to_lsb_out;

  int total = 0;
  int bad   = 0;

  issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .clear_in        (clear_in),
    .inst_valid_in   (inst_valid_in),
    .inst_in         (inst_in),
    .inst_addr_in    (inst_addr_in),
    .full_out        (full_out),
    .count_out       (count_out),
    .rob_full_in     (rob_full_in),
    .rob_tail_id_in  (rob_tail_id_in),
    .rs_full_in      (rs_full_in),
    .lsb_full_in     (lsb_full_in),
    .disp_valid_out  (disp_valid_out),
    .disp_inst_out   (disp_inst_out),
    .disp_addr_out   (disp_addr_out),
    .disp_rob_id_out (disp_rob_id_out),
    .disp_to_rs_out  (disp_to_rs_out),
    .disp_to_lsb_out (disp_to_lsb_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic             rdy, clr, vld;
    logic [31:0]      inst, addr;
    logic             robf;
    logic [ROB_W-1:0] rid;
    logic             rsf, lsbf;
    logic [CW-1:0]    e_cnt;
    logic             e_full, e_dv;
    logic [31:0]      e_inst, e_addr;
    logic [ROB_W-1:0] e_rid;
    logic             e_rs, e_lsb;
  } vec_t;

  vec_t vt [20];

  function automatic vec_t mk(
    input logic rdy, input logic clr, input logic vld,
    input logic [31:0] inst, input logic [31:0] addr,
    input logic robf, input logic [ROB_W-1:0] rid,
    input logic rsf, input logic lsbf,
    input logic [CW-1:0] e_cnt, input logic e_full, input logic e_dv,
    input logic [31:0] e_inst, input logic [31:0] e_addr,
    input logic [ROB_W-1:0] e_rid, input logic e_rs, input logic e_lsb);
    vec_t v;
    v.rdy = rdy; v.clr = clr; v.vld = vld; v.inst = inst; v.addr = addr;
    v.robf = robf; v.rid = rid; v.rsf = rsf; v.lsbf = lsbf;
    v.e_cnt = e_cnt; v.e_full = e_full; v.e_dv = e_dv;
    v.e_inst = e_inst; v.e_addr = e_addr; v.e_rid = e_rid;
    v.e_rs = e_rs; v.e_lsb = e_lsb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    rdy_in = 1'b1; clear_in = 1'b0; inst_valid_in = 1'b0;
    inst_in = '0; inst_addr_in = '0; rob_full_in = 1'b0;
    rob_tail_id_in = '0; rs_full_in = 1'b0; lsb_full_in = 1'b0;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] addr);
    inst_valid_in = 1'b1; inst_in = inst; inst_addr_in = addr;
  endtask

  function automatic logic [31:0] wrap_inst(input int k);
    return 32'h00000033 + (32'(k) << 15);
  endfunction

  initial begin
    idle_inputs();
    rst_in = 1'b0;

    // reset state, no clock edge needed
    #3;
    chk("rst_count", 32'(count_out), 32'd0);
    chk("rst_full", 32'(full_out), 32'd0);
    chk("rst_dv", 32'(disp_valid_out), 32'd0);
    chk("rst_inst", disp_inst_out, 32'd0);
    chk("rst_rs_lsb", 32'({disp_to_rs_out, disp_to_lsb_out}), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;

    //        rdy clr vld inst  addr        robf rid    rsf lsbf | cnt full dv inst addr  rid  rs lsb
    vt[0]  = mk(1, 0, 1, ADD, 32'h0,     0, 5'd3,  0, 0,  5'd1, 0, 0, 32'h0, 32'h0,   5'd0,  0, 0);
    vt[1]  = mk(1, 0, 0, 0,   32'h0,     0, 5'd3,  0, 0,  5'd0, 0, 1, ADD,   32'h0,   5'd3,  1, 0);
    vt[2]  = mk(1, 0, 0, 0,   32'h0,     0, 5'd5,  0, 0,  5'd0, 0, 0, ADD,   32'h0,   5'd3,  0, 0);
    vt[3]  = mk(1, 0, 1, LW,  32'h100,   0, 5'd4,  0, 1,  5'd1, 0, 0, ADD,   32'h0,   5'd3,  0, 0);
    vt[4]  = mk(1, 0, 1, ADD, 32'h104,   0, 5'd4,  0, 1,  5'd2, 0, 0, ADD,   32'h0,   5'd3,  0, 0);
    vt[5]  = mk(1, 0, 0, 0,   32'h0,     0, 5'd4,  0, 1,  5'd2, 0, 0, ADD,   32'h0,   5'd3,  0, 0);
    vt[6]  = mk(1, 0, 0, 0,   32'h0,     0, 5'd7,  0, 0,  5'd1, 0, 1, LW,    32'h100, 5'd7,  0, 1);
    vt[7]  = mk(1, 0, 0, 0,   32'h0,     0, 5'd8,  0, 0,  5'd0, 0, 1, ADD,   32'h104, 5'd8,  1, 0);
    vt[8]  = mk(1, 0, 1, SW,  32'h200,   0, 5'd9,  1, 0,  5'd1, 0, 0, ADD,   32'h104, 5'd8,  0, 0);
    vt[9]  = mk(1, 0, 1, ADD, 32'h204,   0, 5'd9,  1, 0,  5'd1, 0, 1, SW,    32'h200, 5'd9,  0, 1);
    vt[10] = mk(1, 0, 0, 0,   32'h0,     0, 5'd9,  1, 0,  5'd1, 0, 0, SW,    32'h200, 5'd9,  0, 0);
    vt[11] = mk(1, 0, 0, 0,   32'h0,     1, 5'd9,  0, 0,  5'd1, 0, 0, SW,    32'h200, 5'd9,  0, 0);
    vt[12] = mk(0, 0, 1, ADD, 32'h2f0,   0, 5'd10, 0, 0,  5'd1, 0, 0, SW,    32'h200, 5'd9,  0, 0);
    vt[13] = mk(1, 0, 1, ADD, 32'h208,   0, 5'd10, 0, 0,  5'd1, 0, 1, ADD,   32'h204, 5'd10, 1, 0);
    vt[14] = mk(0, 0, 0, 0,   32'h0,     0, 5'd12, 0, 0,  5'd1, 0, 1, ADD,   32'h204, 5'd10, 1, 0);
    vt[15] = mk(1, 0, 0, 0,   32'h0,     0, 5'd11, 0, 0,  5'd0, 0, 1, ADD,   32'h208, 5'd11, 1, 0);
    vt[16] = mk(1, 0, 0, 0,   32'h0,     0, 5'd11, 0, 0,  5'd0, 0, 0, ADD,   32'h208, 5'd11, 0, 0);
    vt[17] = mk(1, 0, 1, ADD, 32'h300,   1, 5'd12, 0, 0,  5'd1, 0, 0, ADD,   32'h208, 5'd11, 0, 0);
    vt[18] = mk(1, 1, 1, ADD, 32'h304,   0, 5'd12, 0, 0,  5'd0, 0, 0, ADD,   32'h208, 5'd11, 0, 0);
    vt[19] = mk(1, 0, 0, 0,   32'h0,     0, 5'd12, 0, 0,  5'd0, 0, 0, ADD,   32'h208, 5'd11, 0, 0);

    for (int i = 0; i < 20; i++) begin
      rdy_in = vt[i].rdy; clear_in = vt[i].clr; inst_valid_in = vt[i].vld;
      inst_in = vt[i].inst; inst_addr_in = vt[i].addr;
      rob_full_in = vt[i].robf; rob_tail_id_in = vt[i].rid;
      rs_full_in = vt[i].rsf; lsb_full_in = vt[i].lsbf;
      tick();
      chk($sformatf("v%0d_count", i), 32'(count_out), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d_full", i), 32'(full_out), 32'(vt[i].e_full));
      chk($sformatf("v%0d_dv", i), 32'(disp_valid_out), 32'(vt[i].e_dv));
      chk($sformatf("v%0d_inst", i), disp_inst_out, vt[i].e_inst);
      chk($sformatf("v%0d_addr", i), disp_addr_out, vt[i].e_addr);
      chk($sformatf("v%0d_rid", i), 32'(disp_rob_id_out), 32'(vt[i].e_rid));
      if (vt[i].e_dv) begin
        chk($sformatf("v%0d_rs", i), 32'(disp_to_rs_out), 32'(vt[i].e_rs));
        chk($sformatf("v%0d_lsb", i), 32'(disp_to_lsb_out), 32'(vt[i].e_lsb));
      end
    end

    // fill to DEPTH behind a full ROB, overflow push, then drain in order
    idle_inputs();
    rob_full_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      push(32'h00000013 | (32'(i) << 20), 32'h1000 + 32'(4 * i));
      tick();
    end
    chk("fill_count", 32'(count_out), 32'(DEPTH));
    chk("fill_full", 32'(full_out), 32'd1);
    push(32'hdead0013, 32'h2000);
    tick();
    chk("overflow_count", 32'(count_out), 32'(DEPTH));
    chk("overflow_full", 32'(full_out), 32'd1);
    rob_full_in = 1'b0;
    tick();
    chk("full_pushpop_count", 32'(count_out), 32'(DEPTH - 1));
    chk("drain0_dv", 32'(disp_valid_out), 32'd1);
    chk("drain0_inst", disp_inst_out, 32'h00000013);
    inst_valid_in = 1'b0;
    for (int i = 1; i < DEPTH; i++) begin
      tick();
      chk($sformatf("drain%0d_dv", i), 32'(disp_valid_out), 32'd1);
      chk($sformatf("drain%0d_inst", i), disp_inst_out, 32'h00000013 | (32'(i) << 20));
      chk($sformatf("drain%0d_addr", i), disp_addr_out, 32'h1000 + 32'(4 * i));
      chk($sformatf("drain%0d_count", i), 32'(count_out), 32'(DEPTH - 1 - i));
    end
    tick();
    chk("drained_dv", 32'(disp_valid_out), 32'd0);
    chk("drained_count", 32'(count_out), 32'd0);

    // flush with five entries and a push on the same edge
    rob_full_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(ADD, 32'h3000 + 32'(4 * i));
      tick();
    end
    chk("pre_clear_count", 32'(count_out), 32'd5);
    clear_in = 1'b1;
    push(ADD, 32'h3ff0);
    tick();
    chk("clear_count", 32'(count_out), 32'd0);
    chk("clear_dv", 32'(disp_valid_out), 32'd0);
    idle_inputs();
    tick();
    chk("post_clear_dv", 32'(disp_valid_out), 32'd0);
    chk("post_clear_count", 32'(count_out), 32'd0);

    // steady push/pop across several pointer wraps
    push(wrap_inst(0), 32'h4000);
    tick();
    chk("wrap_prime_count", 32'(count_out), 32'd1);
    for (int k = 1; k <= 3 * DEPTH; k++) begin
      push(wrap_inst(k), 32'h4000 + 32'(4 * k));
      tick();
      chk($sformatf("wrap%0d_count", k), 32'(count_out), 32'd1);
      chk($sformatf("wrap%0d_dv", k), 32'(disp_valid_out), 32'd1);
      chk($sformatf("wrap%0d_inst", k), disp_inst_out, wrap_inst(k - 1));
      chk($sformatf("wrap%0d_addr", k), disp_addr_out, 32'h4000 + 32'(4 * (k - 1)));
    end
    inst_valid_in = 1'b0;
    tick();
    chk("wrap_last_inst", disp_inst_out, wrap_inst(3 * DEPTH));
    chk("wrap_last_count", 32'(count_out), 32'd0);

    // asynchronous reset mid-stream with seven entries
    rob_full_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push(LW, 32'h5000 + 32'(4 * i));
      tick();
    end
    inst_valid_in = 1'b0;
    rob_full_in = 1'b0;
    rob_tail_id_in = 5'd21;
    tick();
    chk("pre_rst_dv", 32'(disp_valid_out), 32'd1);
    chk("pre_rst_count", 32'(count_out), 32'd6);
    rob_full_in = 1'b1;
    #2;
    rst_in = 1'b0;
    #1;
    chk("arst_dv", 32'(disp_valid_out), 32'd0);
    chk("arst_inst", disp_inst_out, 32'd0);
    chk("arst_addr", disp_addr_out, 32'd0);
    chk("arst_rid", 32'(disp_rob_id_out), 32'd0);
    chk("arst_rs_lsb", 32'({disp_to_rs_out, disp_to_lsb_out}), 32'd0);
    chk("arst_count", 32'(count_out), 32'd0);
    chk("arst_full", 32'(full_out), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    #1;
    chk("rel_count", 32'(count_out), 32'd0);
    push(SW, 32'h6000);
    tick();
    chk("first_push_count", 32'(count_out), 32'd1);
    idle_inputs();
    rob_tail_id_in = 5'd30;
    tick();
    chk("first_disp_dv", 32'(disp_valid_out), 32'd1);
    chk("first_disp_addr", disp_addr_out, 32'h6000);
    chk("first_disp_rid", 32'(disp_rob_id_out), 32'd30);
    chk("first_disp_lsb", 32'(disp_to_lsb_out), 32'd1);
    tick();
    chk("end_dv", 32'(disp_valid_out), 32'd0);
    chk("end_count", 32'(count_out), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
